// File: rtl/ecall_key_unit.sv
`default_nettype none
// ============================================================================
// Module  : ecall_key_unit
// Brief   : Stalls the core during an ecall key-input, waits for a debounced
//           release then press of the confirm button, and captures the switches.
// Revision: 1.0  initial release
// ============================================================================
module ecall_key_unit #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SW_WIDTH        = 16,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  keyin,
  input  logic                  confirm_btn,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  sign_ext,
  output logic                  key_finish,
  output logic [DATA_WIDTH-1:0] key_data,
  output logic                  stall,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_REL   = 3'd1;
  localparam logic [2:0] S_WAIT_PRESS = 3'd2;
  localparam logic [2:0] S_DEBOUNCE   = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  logic                  r_sync0;
  logic                  r_sync1;
  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_btn_s;
  logic                  w_cnt_last;
  logic [DATA_WIDTH-1:0] w_capture;

  assign w_btn_s    = r_sync1;
  assign w_cnt_last = (r_cnt == C_CNT_LAST);
  assign w_capture  = sign_ext ? DATA_WIDTH'($signed(switches))
                               : DATA_WIDTH'(switches);

  assign stall = keyin & ~key_finish;
  assign busy  = (r_state != S_IDLE);

  // Dropping keyin abandons the ecall from any waiting state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (keyin) w_next = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!keyin)                      w_next = S_IDLE;
        else if (!w_btn_s && w_cnt_last) w_next = S_WAIT_PRESS;
      end
      S_WAIT_PRESS: begin
        if (!keyin)       w_next = S_IDLE;
        else if (w_btn_s) w_next = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!keyin)          w_next = S_IDLE;
        else if (!w_btn_s)   w_next = S_WAIT_PRESS;
        else if (w_cnt_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= confirm_btn;
      r_sync1 <= r_sync0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      key_data   <= '0;
      key_finish <= 1'b0;
    end else begin
      r_state    <= w_next;
      key_finish <= (w_next == S_DONE);
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_WAIT_REL)
        r_cnt <= w_btn_s ? '0 : r_cnt + C_CNT_ONE;
      else if (r_state == S_DEBOUNCE)
        r_cnt <= r_cnt + C_CNT_ONE;
      else
        r_cnt <= '0;
      if (r_state == S_DEBOUNCE && w_next == S_DONE)
        key_data <= w_capture;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ecall_key_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ecall_key_unit
// Brief   : Self-checking bench; expected outputs come from a run-length model
//           of the release/press windows over per-cycle stimulus arrays.
// Revision: 1.0  initial release
// ============================================================================
module tb_ecall_key_unit;

  localparam int D    = 4;
  localparam int MAXN = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        keyin;
  logic        confirm_btn;
  logic [15:0] switches;
  logic        sign_ext;
  logic        key_finish;
  logic [31:0] key_data;
  logic        stall;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bit          kin_a  [MAXN];
  bit          btn_a  [MAXN];
  logic [15:0] sw_a   [MAXN];
  bit          fin_e  [MAXN];
  bit          busy_e [MAXN];
  logic [31:0] data_e [MAXN];
  logic [31:0] cap_e  [MAXN];
  logic [31:0] dut_caps[$];

  ecall_key_unit #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .keyin(keyin), .confirm_btn(confirm_btn),
    .switches(switches), .sign_ext(sign_ext), .key_finish(key_finish),
    .key_data(key_data), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext(input logic [15:0] sw, input bit sx);
    longint v;
    v = longint'(sw);
    if (sx && sw >= 16'h8000) v = v + 64'h1_0000_0000 - 64'h1_0000;
    return v[31:0];
  endfunction

  // Button level seen by the debouncer at edge k: raw level two edges earlier.
  function automatic bit s_of(input int k);
    return (k >= 2) ? btn_a[k-2] : 1'b0;
  endfunction

  // Needs D consecutive low samples after entry, then a high sample followed
  // by D more consecutive highs; keyin low at any edge before completion aborts.
  task automatic model(input int n, input bit sx);
    int k;
    int run;
    logic [31:0] cur;
    for (int i = 0; i < MAXN; i++) begin
      fin_e[i] = 0; busy_e[i] = 0; cap_e[i] = '0;
    end
    k = 1;
    while (k < n) begin
      if (!kin_a[k]) begin k++; continue; end
      busy_e[k] = 1;
      k++;
      run = 0;
      while (k < n && kin_a[k] && run < D) begin
        run = s_of(k) ? 0 : run + 1;
        busy_e[k] = 1;
        k++;
      end
      if (k >= n) break;
      if (!kin_a[k]) begin k++; continue; end
      run = 0;
      while (k < n && kin_a[k]) begin
        run = s_of(k) ? run + 1 : 0;
        busy_e[k] = 1;
        if (run == D + 1) begin
          fin_e[k] = 1;
          cap_e[k] = ext(sw_a[k], sx);
          break;
        end
        k++;
      end
      if (k >= n) break;
      k = fin_e[k] ? k + 2 : k + 1;
    end
    cur = '0;
    for (int i = 0; i < n; i++) begin
      if (fin_e[i]) cur = cap_e[i];
      data_e[i] = cur;
    end
  endtask

  task automatic clear_arrays();
    for (int i = 0; i < MAXN; i++) begin
      kin_a[i] = 0; btn_a[i] = 0; sw_a[i] = '0;
    end
  endtask

  task automatic run_scenario(input string name, input int n, input bit sx);
    int pulses_dut, pulses_exp;
    model(n, sx);
    dut_caps.delete();
    pulses_dut = 0;
    pulses_exp = 0;
    @(negedge clk);
    rst = 1; keyin = 0; confirm_btn = 0; sign_ext = sx; switches = sw_a[1];
    @(posedge clk); #1;
    @(negedge clk);
    rst = 0;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      keyin = kin_a[k]; confirm_btn = btn_a[k]; switches = sw_a[k];
      @(posedge clk); #1;
      checks++;
      if (key_finish !== fin_e[k]) begin
        errors++;
        $display("FAIL %s key_finish cyc %0d got %b exp %b", name, k, key_finish, fin_e[k]);
      end
      checks++;
      if (busy !== busy_e[k]) begin
        errors++;
        $display("FAIL %s busy cyc %0d got %b exp %b", name, k, busy, busy_e[k]);
      end
      checks++;
      if (key_data !== data_e[k]) begin
        errors++;
        $display("FAIL %s key_data cyc %0d got %h exp %h", name, k, key_data, data_e[k]);
      end
      checks++;
      if (stall !== (kin_a[k] & ~fin_e[k])) begin
        errors++;
        $display("FAIL %s stall cyc %0d got %b exp %b", name, k, stall, kin_a[k] & ~fin_e[k]);
      end
      if (key_finish === 1'b1) begin
        pulses_dut++;
        dut_caps.push_back(key_data);
      end
      if (fin_e[k]) pulses_exp++;
    end
    checks++;
    if (pulses_dut != pulses_exp) begin
      errors++;
      $display("FAIL %s pulse_count got %0d exp %0d", name, pulses_dut, pulses_exp);
    end
  endtask

  task automatic expect_caps(input string name, input logic [31:0] exp_q[$]);
    checks++;
    if (dut_caps.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s capture_count got %0d exp %0d", name, dut_caps.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (dut_caps[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s capture%0d got %h exp %h", name, i, dut_caps[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; keyin = 0; confirm_btn = 0; switches = 16'h1234; sign_ext = 0;
    #3;
    checks++;
    if (key_finish !== 1'b0 || busy !== 1'b0 || key_data !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got fin=%b busy=%b data=%h stall=%b exp 0/0/0/0",
               key_finish, busy, key_data, stall);
    end
    keyin = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_keyin got %b exp 1", stall);
    end
    keyin = 0;
  endtask

  task automatic basic_arrays(input logic [15:0] sw, input int n);
    clear_arrays();
    for (int k = 1; k < n; k++) begin
      kin_a[k] = 1; btn_a[k] = (k >= 9); sw_a[k] = sw;
    end
  endtask

  task automatic test_basic();
    basic_arrays(16'h00A5, 25);
    run_scenario("basic", 25, 1'b0);
    expect_caps("basic", '{32'h000000A5});
  endtask

  task automatic test_sign_ext();
    basic_arrays(16'h8001, 25);
    run_scenario("sext1", 25, 1'b1);
    expect_caps("sext1", '{32'hFFFF8001});
    basic_arrays(16'h8001, 25);
    run_scenario("sext0", 25, 1'b0);
    expect_caps("sext0", '{32'h00008001});
  endtask

  task automatic test_bounce();
    bit pat[6] = '{1, 1, 0, 1, 1, 0};
    clear_arrays();
    for (int k = 1; k < 40; k++) begin
      kin_a[k] = 1; sw_a[k] = 16'h0042;
      if (k <= 8)       btn_a[k] = 0;
      else if (k <= 14) btn_a[k] = pat[k-9];
      else              btn_a[k] = 1;
    end
    run_scenario("bounce", 40, 1'b0);
    expect_caps("bounce", '{32'h00000042});
  endtask

  task automatic test_held_at_entry();
    clear_arrays();
    for (int k = 1; k < 51; k++) begin
      kin_a[k] = 1; sw_a[k] = 16'h0011;
      btn_a[k] = (k <= 22) || (k >= 29);
    end
    run_scenario("held", 51, 1'b0);
    expect_caps("held", '{32'h00000011});
  endtask

  task automatic test_abort();
    clear_arrays();
    for (int k = 1; k < 41; k++) begin
      kin_a[k] = (k <= 33);
      btn_a[k] = (k >= 9 && k <= 20) || (k >= 30);
      sw_a[k]  = (k <= 16) ? 16'h0055 : 16'h0AAA;
    end
    run_scenario("abort", 41, 1'b0);
    expect_caps("abort", '{32'h00000055});
    checks++;
    if (key_data !== 32'h00000055) begin
      errors++;
      $display("FAIL abort_keeps_data got %h exp %h", key_data, 32'h00000055);
    end
  endtask

  task automatic test_reset_mid();
    basic_arrays(16'h00A5, 13);
    run_scenario("midrst_pre", 13, 1'b0);
    #2;
    rst = 1;
    #1;
    checks++;
    if (key_finish !== 1'b0 || busy !== 1'b0 || key_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got fin=%b busy=%b data=%h exp 0/0/0",
               key_finish, busy, key_data);
    end
    @(negedge clk);
    keyin = 0; confirm_btn = 0; rst = 0;
  endtask

  task automatic test_back_to_back();
    clear_arrays();
    for (int k = 1; k < 40; k++) begin
      kin_a[k] = 1;
      btn_a[k] = (k >= 9 && k <= 18) || (k >= 27);
      sw_a[k]  = (k < 20) ? 16'h0003 : 16'h0007;
    end
    run_scenario("b2b", 40, 1'b0);
    expect_caps("b2b", '{32'h00000003, 32'h00000007});
  endtask

  task automatic test_random();
    bit kl, bl;
    logic [31:0] exp_q[$];
    for (int r = 0; r < 6; r++) begin
      clear_arrays();
      kl = 1; bl = 0;
      sw_a[0] = 16'($urandom);
      for (int k = 1; k < 150; k++) begin
        if ($urandom_range(0, 39) == 0) kl = ~kl;
        if ($urandom_range(0, 5) == 0)  bl = ~bl;
        kin_a[k] = kl; btn_a[k] = bl;
        sw_a[k] = ($urandom_range(0, 49) == 0) ? 16'($urandom) : sw_a[k-1];
      end
      run_scenario("random", 150, 1'($urandom_range(0, 1)));
      exp_q.delete();
      for (int k = 1; k < 150; k++) if (fin_e[k]) exp_q.push_back(cap_e[k]);
      expect_caps("random", exp_q);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_ext();
    test_bounce();
    test_held_at_entry();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
